store_checker: RTL and testbench

- Synthesizable self-checking monitor for the superscalar data path. It compares up to PORTS data-memory writes per cycle against an ordered list of expected (address, data) stores.
- Reports sticky pass/fail/timeout status and captures the first mismatch.
- Generalises single-store end-of-program checking to multi-port, multi-store, in-order checking with a watchdog. Usable in simulation benches and on FPGA status LEDs.

---
 rtl/store_checker_pkg.sv | 33 +++
 rtl/store_checker_if.sv | 44 ++++
 rtl/store_checker_peek_fifo.sv | 60 ++++++
 rtl/store_checker.sv | 178 +++++++++++++++++
 tb/tb_store_checker.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/store_checker_pkg.sv
// store_checker_pkg: shared types and width helpers for the store checker.
//   state_e     - checker FSM states (IDLE, RUN, PASS, FAIL, TIMEOUT)
//   cnt_w()     - width of a 0..DEPTH counter (match count, FIFO occupancy)
//   ptr_w()     - width of a FIFO pointer (DEPTH is a power of two)
//   port_w()    - width of a port index (minimum 1 bit)
//   sel_w()     - width of a 0..PORTS pop/active-port count
package store_checker_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_PASS,
    ST_FAIL,
    ST_TIMEOUT
  } state_e;

  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int unsigned port_w(input int unsigned ports);
    return (ports > 1) ? $clog2(ports) : 1;
  endfunction

  function automatic int unsigned sel_w(input int unsigned ports);
    return $clog2(ports + 1);
  endfunction

endpackage

// File: rtl/store_checker_if.sv
// store_checker_if: bundle of the expected-store push channel, the observed
// memory-write ports and the status/error outputs of store_checker.
//   master - bench/SoC side: drives pushes, start and memory writes
//   slave  - checker side: drives exp_ready, status flags and error capture
interface store_checker_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned PORTS = 2,
  parameter int unsigned DEPTH = 8
);
  import store_checker_pkg::*;

  localparam int unsigned CNT_W  = cnt_w(DEPTH);
  localparam int unsigned PIDX_W = port_w(PORTS);

  logic                   exp_valid;
  logic [WIDTH-1:0]       exp_addr;
  logic [WIDTH-1:0]       exp_data;
  logic                   exp_ready;
  logic                   start;
  logic [PORTS-1:0]       memwrite;
  logic [PORTS*WIDTH-1:0] addr;
  logic [PORTS*WIDTH-1:0] wdata;
  logic                   busy;
  logic                   pass;
  logic                   fail;
  logic                   timeout;
  logic [CNT_W-1:0]       match_count;
  logic [PIDX_W-1:0]      err_port;
  logic [WIDTH-1:0]       err_addr;
  logic [WIDTH-1:0]       err_data;

  modport master (
    output exp_valid, exp_addr, exp_data, start, memwrite, addr, wdata,
    input  exp_ready, busy, pass, fail, timeout, match_count,
           err_port, err_addr, err_data
  );

  modport slave (
    input  exp_valid, exp_addr, exp_data, start, memwrite, addr, wdata,
    output exp_ready, busy, pass, fail, timeout, match_count,
           err_port, err_addr, err_data
  );

endinterface

// File: rtl/store_checker_peek_fifo.sv
// peek_fifo: synchronous FIFO with one push per cycle, a PORTS-wide read
// window starting at the head, and a variable pop of 0..PORTS entries.
//   clk_i, rst_i   - clock, synchronous active-high reset
//   push_i         - push request (dropped when full)
//   push_data_i    - entry to push
//   pop_cnt_i      - number of entries to pop this cycle (<= count_o)
//   win_o[j]       - entry at head+j (wraps modulo DEPTH)
//   count_o        - occupancy 0..DEPTH
//   full_o/empty_o - occupancy flags
module peek_fifo #(
  parameter int unsigned DW    = 64,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned PORTS = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic [DW-1:0]              push_data_i,
  input  logic [$clog2(PORTS+1)-1:0] pop_cnt_i,
  output logic [DW-1:0]              win_o [PORTS],
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);
  import store_checker_pkg::*;

  localparam int unsigned PTR_W = ptr_w(DEPTH);

  logic [DW-1:0]    mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             push_ok;

  assign push_ok = push_i && !full_o;
  assign count_o = count_q;
  assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty_o = (count_q == '0);

  // Pointer arithmetic wraps naturally because DEPTH is a power of two.
  for (genvar j = 0; j < PORTS; j++) begin : g_win
    assign win_o[j] = mem_q[rd_ptr_q + PTR_W'(j)];
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      rd_ptr_q <= rd_ptr_q + PTR_W'(pop_cnt_i);
      count_q  <= count_q + (PTR_W+1)'(push_ok) - (PTR_W+1)'(pop_cnt_i);
    end
  end

endmodule

// File: rtl/store_checker.sv
// store_checker: self-checking monitor comparing up to PORTS memory writes
// per cycle against an ordered list of expected (address, data) stores.
//   clk   - clock, all state changes on the rising edge
//   reset - synchronous active-high reset, clears all state and flags
//   bus   - store_checker_if slave: expected-store push (exp_valid/addr/data,
//           exp_ready), start, observed writes (memwrite/addr/wdata), status
//           (busy/pass/fail/timeout/match_count) and first-error capture
//           (err_port/err_addr/err_data)
module store_checker #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned PORTS   = 2,
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic          clk,
  input  logic          reset,
  store_checker_if.slave bus
);
  import store_checker_pkg::*;

  localparam int unsigned CNT_W  = cnt_w(DEPTH);
  localparam int unsigned PIDX_W = port_w(PORTS);
  localparam int unsigned SEL_W  = sel_w(PORTS);
  localparam int unsigned WD_W   = $clog2(TIMEOUT + 1);
  localparam int unsigned DW     = 2 * WIDTH;

  state_e            state_q, state_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic [CNT_W-1:0]  mc_q, mc_d;
  logic [PIDX_W-1:0] ep_q, ep_d;
  logic [WIDTH-1:0]  ea_q, ea_d;
  logic [WIDTH-1:0]  ed_q, ed_d;

  logic                   fifo_push;
  logic [SEL_W-1:0]       pop_cnt;
  logic [DW-1:0]          win [PORTS];
  logic [$clog2(DEPTH):0] fifo_count;
  logic                   fifo_full;
  logic                   fifo_empty;

  logic [WIDTH-1:0] p_addr [PORTS];
  logic [WIDTH-1:0] p_data [PORTS];

  int unsigned       n_ok;
  logic              hit_err;
  logic [PIDX_W-1:0] hit_port;
  logic [WIDTH-1:0]  hit_addr;
  logic [WIDTH-1:0]  hit_data;

  for (genvar i = 0; i < PORTS; i++) begin : g_port
    assign p_addr[i] = bus.addr[i*WIDTH +: WIDTH];
    assign p_data[i] = bus.wdata[i*WIDTH +: WIDTH];
  end

  assign bus.exp_ready = (state_q == ST_IDLE) && !fifo_full;
  assign fifo_push     = bus.exp_valid && bus.exp_ready;

  peek_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .PORTS (PORTS)
  ) u_fifo (
    .clk_i       (clk),
    .rst_i       (reset),
    .push_i      (fifo_push),
    .push_data_i ({bus.exp_addr, bus.exp_data}),
    .pop_cnt_i   (pop_cnt),
    .win_o       (win),
    .count_o     (fifo_count),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  // The j-th strobed port is checked against head+j. Comparison is written
  // as "if (match) ok else error" so that an X on a strobed port falls into
  // the error branch. In PASS the FIFO is empty, so every strobe fails and
  // hit_port is simply the lowest strobed port.
  always_comb begin
    n_ok     = 0;
    hit_err  = 1'b0;
    hit_port = '0;
    hit_addr = '0;
    hit_data = '0;
    for (int unsigned i = 0; i < PORTS; i++) begin
      if (bus.memwrite[i] && !hit_err) begin
        if ((n_ok < 32'(fifo_count)) &&
            (p_addr[i] == win[n_ok][DW-1:WIDTH]) &&
            (p_data[i] == win[n_ok][WIDTH-1:0])) begin
          n_ok = n_ok + 1;
        end else begin
          hit_err  = 1'b1;
          hit_port = PIDX_W'(i);
          hit_addr = p_addr[i];
          hit_data = p_data[i];
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    wd_d    = wd_q;
    mc_d    = mc_q;
    ep_d    = ep_q;
    ea_d    = ea_q;
    ed_d    = ed_q;
    pop_cnt = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          // A push accepted in the same cycle already makes the list non-empty.
          if (!fifo_empty || fifo_push) begin
            state_d = ST_RUN;
            wd_d    = '0;
          end else begin
            state_d = ST_PASS;
          end
        end
      end
      ST_RUN: begin
        if (hit_err) begin
          state_d = ST_FAIL;
          ep_d    = hit_port;
          ea_d    = hit_addr;
          ed_d    = hit_data;
        end else begin
          pop_cnt = SEL_W'(n_ok);
          mc_d    = mc_q + CNT_W'(n_ok);
          if (n_ok == 32'(fifo_count)) begin
            state_d = ST_PASS;
          end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
            state_d = ST_TIMEOUT;
          end else begin
            wd_d = wd_q + 1'b1;
          end
        end
      end
      ST_PASS: begin
        if (hit_err) begin
          state_d = ST_FAIL;
          ep_d    = hit_port;
          ea_d    = hit_addr;
          ed_d    = hit_data;
        end
      end
      ST_FAIL, ST_TIMEOUT: ;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      wd_q    <= '0;
      mc_q    <= '0;
      ep_q    <= '0;
      ea_q    <= '0;
      ed_q    <= '0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
      mc_q    <= mc_d;
      ep_q    <= ep_d;
      ea_q    <= ea_d;
      ed_q    <= ed_d;
    end
  end

  assign bus.busy        = (state_q == ST_RUN);
  assign bus.pass        = (state_q == ST_PASS);
  assign bus.fail        = (state_q == ST_FAIL);
  assign bus.timeout     = (state_q == ST_TIMEOUT);
  assign bus.match_count = mc_q;
  assign bus.err_port    = ep_q;
  assign bus.err_addr    = ea_q;
  assign bus.err_data    = ed_q;

endmodule

// File: tb/tb_store_checker.sv
module tb_store_checker;

  localparam int unsigned W  = 32;
  localparam int unsigned P  = 2;
  localparam int unsigned D  = 8;
  localparam int unsigned TO = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  store_checker_if #(.WIDTH(W), .PORTS(P), .DEPTH(D)) bus ();

  store_checker #(
    .WIDTH   (W),
    .PORTS   (P),
    .DEPTH   (D),
    .TIMEOUT (TO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    string       name;
    int unsigned at;
    logic        p, f, t;
    int unsigned mc;
    int unsigned ep;
    logic [31:0] ea, ed;
  } ev_t;

  ev_t q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: each rise/change of the terminal flags is one DUT response,
  // checked against the oldest queued expectation.
  logic [2:0] prev = 3'b000;
  always @(negedge clk) begin
    logic [2:0] st;
    ev_t e;
    st = {bus.pass, bus.fail, bus.timeout};
    if (reset) begin
      prev = 3'b000;
    end else begin
      if (st != prev && st != 3'b000) begin
        if (q.size() == 0) begin
          chk("unexpected_event", {29'b0, st}, 32'h0);
        end else begin
          e = q.pop_front();
          chk({e.name, ".cycle"},   e.at === cyc ? 32'h0 : cyc, 32'h0);
          chk({e.name, ".pass"},    {31'b0, bus.pass},    {31'b0, e.p});
          chk({e.name, ".fail"},    {31'b0, bus.fail},    {31'b0, e.f});
          chk({e.name, ".timeout"}, {31'b0, bus.timeout}, {31'b0, e.t});
          chk({e.name, ".busy"},    {31'b0, bus.busy},    32'h0);
          chk({e.name, ".match_count"}, 32'(bus.match_count), e.mc);
          chk({e.name, ".err_port"},    32'(bus.err_port),    e.ep);
          chk({e.name, ".err_addr"},    bus.err_addr,         e.ea);
          chk({e.name, ".err_data"},    bus.err_data,         e.ed);
        end
      end
      prev = st;
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.exp_valid = 1'b0;
    bus.exp_addr  = '0;
    bus.exp_data  = '0;
    bus.start     = 1'b0;
    bus.memwrite  = '0;
    bus.addr      = '0;
    bus.wdata     = '0;
  endtask

  task automatic check_clear(input string name);
    chk({name, ".busy"},        {31'b0, bus.busy},      32'h0);
    chk({name, ".pass"},        {31'b0, bus.pass},      32'h0);
    chk({name, ".fail"},        {31'b0, bus.fail},      32'h0);
    chk({name, ".timeout"},     {31'b0, bus.timeout},   32'h0);
    chk({name, ".exp_ready"},   {31'b0, bus.exp_ready}, 32'h1);
    chk({name, ".match_count"}, 32'(bus.match_count),   32'h0);
    chk({name, ".err_addr"},    bus.err_addr,           32'h0);
    chk({name, ".err_data"},    bus.err_data,           32'h0);
  endtask

  task automatic do_reset(input string name);
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    check_clear(name);
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d);
    bus.exp_valid = 1'b1;
    bus.exp_addr  = a;
    bus.exp_data  = d;
    tick();
    bus.exp_valid = 1'b0;
  endtask

  task automatic start_chk();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wr(input logic [1:0] mw, input logic [31:0] a0, input logic [31:0] d0,
                    input logic [31:0] a1, input logic [31:0] d1);
    bus.memwrite = mw;
    bus.addr     = {a1, a0};
    bus.wdata    = {d1, d0};
    tick();
    bus.memwrite = '0;
  endtask

  task automatic expect_ev(input string name, input int unsigned dt,
                           input logic p, input logic f, input logic t,
                           input int unsigned mc, input int unsigned ep,
                           input logic [31:0] ea, input logic [31:0] ed);
    q.push_back('{name, cyc + dt, p, f, t, mc, ep, ea, ed});
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 40 && q.size() != 0; i++) tick();
    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: %0d expected responses never seen, required 0", name, q.size());
      q.delete();
    end
    tick();
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1, "global timeout");
  end

  initial begin
    idle_inputs();
    do_reset("reset0");

    // Dot-product single store
    push(32'h0, 32'd4985);
    start_chk();
    expect_ev("dot", 1, 1, 0, 0, 1, 0, 0, 0);
    wr(2'b01, 32'h0, 32'd4985, 0, 0);
    drain("dot");

    // Dual-issue match
    do_reset("reset_dual");
    push(32'h4, 32'd7);
    push(32'h8, 32'd9);
    start_chk();
    expect_ev("dual", 1, 1, 0, 0, 2, 0, 0, 0);
    wr(2'b11, 32'h4, 32'd7, 32'h8, 32'd9);
    drain("dual");

    // Data mismatch on port 1: nothing popped
    do_reset("reset_mis");
    push(32'h4, 32'd7);
    push(32'h8, 32'd9);
    start_chk();
    expect_ev("mismatch", 1, 0, 1, 0, 0, 1, 32'h8, 32'd10);
    wr(2'b11, 32'h4, 32'd7, 32'h8, 32'd10);
    drain("mismatch");

    // Store after pass
    do_reset("reset_after");
    push(32'h0, 32'd1);
    start_chk();
    expect_ev("after_pass", 1, 1, 0, 0, 1, 0, 0, 0);
    wr(2'b01, 32'h0, 32'd1, 0, 0);
    expect_ev("after_fail", 1, 0, 1, 0, 1, 0, 32'hC, 32'd3);
    wr(2'b01, 32'hC, 32'd3, 0, 0);
    drain("after");

    // Two strobes with one entry left
    do_reset("reset_extra");
    push(32'h0, 32'd1);
    push(32'h4, 32'd2);
    start_chk();
    wr(2'b01, 32'h0, 32'd1, 0, 0);
    chk("extra.mid_count", 32'(bus.match_count), 32'd1);
    expect_ev("extra", 1, 0, 1, 0, 1, 1, 32'h8, 32'd5);
    wr(2'b11, 32'h4, 32'd2, 32'h8, 32'd5);
    drain("extra");

    // Port 1 alone takes the head entry
    do_reset("reset_p1");
    push(32'h10, 32'h11);
    start_chk();
    expect_ev("port1_only", 1, 1, 0, 0, 1, 0, 0, 0);
    wr(2'b10, 32'h0, 32'h0, 32'h10, 32'h11);
    drain("port1_only");

    // Watchdog: timeout 16 cycles after the start edge
    do_reset("reset_to");
    push(32'h0, 32'd1);
    expect_ev("timeout", 17, 0, 0, 1, 0, 0, 0, 0);
    start_chk();
    drain("timeout");
    wr(2'b01, 32'h0, 32'd1, 0, 0);
    tick();
    chk("timeout.hold",      {31'b0, bus.timeout}, 32'h1);
    chk("timeout.hold_pass", {31'b0, bus.pass},    32'h0);
    chk("timeout.hold_mc",   32'(bus.match_count), 32'h0);

    // Capacity: full FIFO refuses the next push
    do_reset("reset_cap");
    for (int i = 0; i < 8; i++) push(32'(i * 4), 32'(100 + i));
    chk("cap.exp_ready_full", {31'b0, bus.exp_ready}, 32'h0);
    push(32'h100, 32'h55);
    start_chk();
    wr(2'b11, 32'h0, 32'd100, 32'h4, 32'd101);
    wr(2'b11, 32'h8, 32'd102, 32'hC, 32'd103);
    chk("cap.mid_count", 32'(bus.match_count), 32'd4);
    chk("cap.mid_busy",  {31'b0, bus.busy},    32'h1);
    wr(2'b11, 32'h10, 32'd104, 32'h14, 32'd105);
    expect_ev("cap", 1, 1, 0, 0, 8, 0, 0, 0);
    wr(2'b11, 32'h18, 32'd106, 32'h1C, 32'd107);
    drain("cap");

    // Reset mid-RUN clears the FIFO; start on empty list passes
    do_reset("reset_mid0");
    push(32'h0, 32'd1);
    start_chk();
    tick();
    chk("mid.busy_before", {31'b0, bus.busy}, 32'h1);
    do_reset("reset_mid");
    expect_ev("empty_start", 1, 1, 0, 0, 0, 0, 0, 0);
    start_chk();
    drain("empty_start");

    // Writes ignored in IDLE; push and start in the same cycle
    do_reset("reset_combo");
    wr(2'b01, 32'h0, 32'd1, 0, 0);
    bus.exp_valid = 1'b1;
    bus.exp_addr  = 32'h20;
    bus.exp_data  = 32'h21;
    bus.start     = 1'b1;
    tick();
    bus.exp_valid = 1'b0;
    bus.start     = 1'b0;
    chk("combo.busy", {31'b0, bus.busy}, 32'h1);
    expect_ev("combo", 1, 1, 0, 0, 1, 0, 0, 0);
    wr(2'b01, 32'h20, 32'h21, 0, 0);
    drain("combo");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
